apb_memif_bridge: RTL and testbench

APB_MEMIF_BRIDGE -- requirements
Module: apb_memif_bridge

---
 rtl/apb_memif_bridge.sv | 119 +++++++++++
 tb/tb_apb_memif_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_memif_bridge.sv
// APB responder to simple request/acknowledge memory initiator bridge.
// Handles one APB transfer at a time, with a bounded wait for the memory acknowledge.
module apb_memif_bridge #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // APB responder
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  // memory initiator
  output logic                    mreq_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic                    mwe_o,
  output logic [DATA_WIDTH-1:0]   mwdata_o,
  output logic [DATA_WIDTH/8-1:0] mstrb_o,
  input  logic                    mack_i,
  input  logic [DATA_WIDTH-1:0]   mrdata_i,
  input  logic                    mresp_i,
  // FSM state observation
  output logic [1:0]              dbg_state_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_BITS   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_WIDTH  = (CNT_BITS > 5) ? CNT_BITS : 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic setup_phase;
  logic timeout;
  logic resp_valid;

  // Handshakes: a memory request is held (mreq_o with stable address/data) from the
  // first ACCESS cycle until the cycle mack_i is seen high, including the same cycle;
  // the APB side completes only in the single DONE cycle, and only if the requester
  // is still in its access phase (psel_i & penable_i) -- otherwise the result is dropped.
  assign setup_phase = psel_i & ~penable_i;
  assign timeout     = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_phase) state_d = ACCESS;
      ACCESS:  if (mack_i || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup_phase) begin
        addr_q  <= paddr_i;
        we_q    <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= pstrb_i;
        cnt_q   <= '0;
      end
      if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
        // An acknowledge on the last allowed cycle still wins over the timeout.
        if (mack_i) begin
          rdata_q <= we_q ? '0 : mrdata_i;
          err_q   <= mresp_i;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign mreq_o   = (state_q == ACCESS);
  assign maddr_o  = addr_q;
  assign mwe_o    = we_q;
  assign mwdata_o = wdata_q;
  assign mstrb_o  = we_q ? strb_q : '0;

  assign resp_valid = (state_q == DONE) & psel_i & penable_i;
  assign pready_o   = resp_valid;
  assign prdata_o   = resp_valid ? rdata_q : '0;
  assign pslverr_o  = resp_valid & err_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_memif_bridge.sv
// Bench for apb_memif_bridge: directed scenarios plus randomized transfers, each
// predicted by a per-transfer timing/response model derived from the bridge rules.
module tb_apb_memif_bridge;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          psel_i, penable_i, pwrite_i;
  logic [AW-1:0] paddr_i;
  logic [DW-1:0] pwdata_i;
  logic [SW-1:0] pstrb_i;
  logic          pready_o, pslverr_o;
  logic [DW-1:0] prdata_o;
  logic          mreq_o, mwe_o;
  logic [AW-1:0] maddr_o;
  logic [DW-1:0] mwdata_o;
  logic [SW-1:0] mstrb_o;
  logic          mack_i, mresp_i;
  logic [DW-1:0] mrdata_i;
  logic [1:0]    dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_memif_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i), .pwrite_i(pwrite_i),
    .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .pready_o(pready_o), .prdata_o(prdata_o),
    .pslverr_o(pslverr_o),
    .mreq_o(mreq_o), .maddr_o(maddr_o), .mwe_o(mwe_o), .mwdata_o(mwdata_o),
    .mstrb_o(mstrb_o), .mack_i(mack_i), .mrdata_i(mrdata_i), .mresp_i(mresp_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mreq"}, 64'(mreq_o), 64'd0);
    chk({tag, "_maddr"}, 64'(maddr_o), 64'd0);
    chk({tag, "_mwe"}, 64'(mwe_o), 64'd0);
    chk({tag, "_mwdata"}, 64'(mwdata_o), 64'd0);
    chk({tag, "_mstrb"}, 64'(mstrb_o), 64'd0);
    chk({tag, "_pready"}, 64'(pready_o), 64'd0);
    chk({tag, "_prdata"}, 64'(prdata_o), 64'd0);
    chk({tag, "_pslverr"}, 64'(pslverr_o), 64'd0);
  endtask

  // Idle cycles with stray acknowledges that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0;
      mack_i = 1'($urandom_range(0, 1)); mrdata_i = DW'($urandom); mresp_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      chk("idle_mreq", 64'(mreq_o), 64'd0);
      chk("idle_pready", 64'(pready_o), 64'd0);
    end
  endtask

  // One APB transfer. dly = cycles between mreq_o rising and mack_i (0 = same cycle);
  // dly >= TIMEOUT means the acknowledge never arrives inside the access window.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input int dly, input logic resp,
                      input logic [DW-1:0] rdata, input logic keep_sel);
    int            n_req;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    logic          ack_now, in_access, resp_cycle;
    n_req    = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
    exp_err  = (dly < TIMEOUT) ? resp : 1'b1;
    exp_data = (dly < TIMEOUT && !wr) ? rdata : '0;
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr;
    pwdata_i = wdata; pstrb_i = strb;
    mack_i = 1'b0; mrdata_i = DW'($urandom); mresp_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    chk("setup_mreq", 64'(mreq_o), 64'd0);
    chk("setup_pready", 64'(pready_o), 64'd0);
    for (int c = 1; c <= n_req + 1; c++) begin
      @(posedge clk_i); #1;
      psel_i = keep_sel; penable_i = keep_sel;
      paddr_i = AW'($urandom); pwdata_i = DW'($urandom); pstrb_i = SW'($urandom);
      ack_now  = (c == dly + 1);
      mack_i   = ack_now;
      mrdata_i = ack_now ? rdata : DW'($urandom);
      mresp_i  = ack_now ? resp : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      in_access  = (c <= n_req);
      resp_cycle = (c == n_req + 1) && keep_sel;
      chk("mreq", 64'(mreq_o), 64'(in_access));
      chk("maddr", 64'(maddr_o), 64'(addr));
      chk("mwe", 64'(mwe_o), 64'(wr));
      chk("mwdata", 64'(mwdata_o), 64'(wdata));
      chk("mstrb", 64'(mstrb_o), wr ? 64'(strb) : 64'd0);
      chk("pready", 64'(pready_o), 64'(resp_cycle));
      chk("prdata", 64'(prdata_o), resp_cycle ? 64'(exp_data) : 64'd0);
      chk("pslverr", 64'(pslverr_o), resp_cycle ? 64'(exp_err) : 64'd0);
    end
  endtask

  initial begin
    int dly, r;
    // reset
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; paddr_i = '0; pwrite_i = 1'b0;
    pwdata_i = '0; pstrb_i = '0; mack_i = 1'b0; mrdata_i = '0; mresp_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // write, same-cycle ack, first transfer after reset
    xfer(5'h04, 1'b1, 32'h1234, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    idle(1);
    // read, ack 3 cycles after request, error response
    xfer(5'h14, 1'b0, 32'h0, 4'hF, 3, 1'b1, 32'hA5, 1'b1);
    idle(1);
    // read timeout, late ack in DONE cycle must be ignored
    xfer(5'h08, 1'b0, 32'h0, 4'h3, 16, 1'b0, 32'hDEAD, 1'b1);
    idle(2);
    // read timeout, no ack at all
    xfer(5'h09, 1'b0, 32'h0, 4'h3, 40, 1'b0, 32'h0, 1'b1);
    idle(1);
    // ack on the last allowed cycle wins over the timeout
    xfer(5'h0C, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h55, 1'b1);
    idle(1);

    // psel_i+penable_i without setup phase is ignored
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b1; paddr_i = 5'h1F; pwrite_i = 1'b1;
      @(negedge clk_i);
      chk("nosetup_mreq", 64'(mreq_o), 64'd0);
      chk("nosetup_pready", 64'(pready_o), 64'd0);
    end
    idle(1);

    // requester walks away during ACCESS: memory side still completes, response dropped
    xfer(5'h11, 1'b1, 32'hCAFE, 4'h5, 2, 1'b1, 32'h0, 1'b0);
    idle(2);

    // reset in the middle of ACCESS
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 5'h0A; pwrite_i = 1'b1;
    pwdata_i = 32'h77; pstrb_i = 4'hF; mack_i = 1'b0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("prerst_mreq", 64'(mreq_o), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("midrst");
    idle(3);
    xfer(5'h0B, 1'b1, 32'h99, 4'hC, 2, 1'b0, 32'h0, 1'b1);

    // back-to-back writes
    xfer(5'h01, 1'b1, 32'h1111, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    xfer(5'h02, 1'b1, 32'h2222, 4'h3, 1, 1'b0, 32'h0, 1'b1);
    idle(1);

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      dly = int'($urandom_range(0, 4));
      else if (r < 8) dly = int'($urandom_range(5, 17));
      else            dly = int'($urandom_range(14, 20));
      xfer(AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), SW'($urandom), dly,
           1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 7) != 0));
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
